// File: rtl/uff_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uff_pkg
// Brief   : Mode encodings and per-bit next-state function for universal_ff_bank.
// Revision: 1.0
// ============================================================================
package uff_pkg;

    localparam logic [1:0] UFF_D  = 2'b00;
    localparam logic [1:0] UFF_T  = 2'b01;
    localparam logic [1:0] UFF_JK = 2'b10;
    localparam logic [1:0] UFF_SR = 2'b11;

    // An S=R=1 pair in SR mode holds the bit; the error is flagged separately.
    function automatic logic uff_next(
        input logic [1:0] mode,
        input logic       q,
        input logic       a,
        input logic       b
    );
        logic r;
        r = q;
        case (mode)
            UFF_D:   r = a;
            UFF_T:   r = q ^ a;
            UFF_JK:  r = (a & ~q) | (~b & q);
            UFF_SR:  r = (a & ~b) ? 1'b1 : ((~a & b) ? 1'b0 : q);
            default: r = q;
        endcase
        return r;
    endfunction

endpackage : uff_pkg
`default_nettype wire

// File: rtl/uff_cell.sv
`default_nettype none
// ============================================================================
// Module  : uff_cell
// Brief   : One flip-flop channel: next state and illegal-SR detection.
// Revision: 1.0
// ============================================================================
module uff_cell
    import uff_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       q,
    input  logic       a,
    input  logic       b,
    output logic       next_q,
    output logic       illegal_sr
);

    assign next_q     = uff_next(mode, q, a, b);
    assign illegal_sr = (mode == UFF_SR) & a & b;

endmodule : uff_cell
`default_nettype wire

// File: rtl/universal_ff_bank.sv
`default_nettype none
// ============================================================================
// Module  : universal_ff_bank
// Brief   : WIDTH-bit bank of D/T/JK/SR flip-flops with enable, sticky SR
//           error flag, change pulse and optional saturating toggle counter
//           (enabled by macro UFF_TOGGLE_CNT_EN).
// Revision: 1.0
// ============================================================================
module universal_ff_bank
    import uff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             q_chg,
`ifdef UFF_TOGGLE_CNT_EN
    output logic [CNT_W-1:0] toggle_cnt,
`endif
    output logic             sr_err
);

    logic [WIDTH-1:0] r_q;
    logic             r_q_chg;
    logic             r_sr_err;
    logic [WIDTH-1:0] w_next_q;
    logic [WIDTH-1:0] w_illegal;
    logic             w_sr_set;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        uff_cell u_cell (
            .mode       (mode),
            .q          (r_q[gi]),
            .a          (a[gi]),
            .b          (b[gi]),
            .next_q     (w_next_q[gi]),
            .illegal_sr (w_illegal[gi])
        );
    end

    assign w_sr_set = en & (|w_illegal);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= RST_VAL;
            r_q_chg  <= 1'b0;
            r_sr_err <= 1'b0;
        end else begin
            if (en) begin
                r_q <= w_next_q;
            end
            r_q_chg <= en & (w_next_q != r_q);
            // Set has priority over a simultaneous clear.
            if (w_sr_set) begin
                r_sr_err <= 1'b1;
            end else if (clr_err) begin
                r_sr_err <= 1'b0;
            end
        end
    end

`ifdef UFF_TOGGLE_CNT_EN
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] c_cnt_max = SUM_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_diff;
    logic [PC_W-1:0]  w_pc;
    logic [SUM_W-1:0] w_sum;

    assign w_diff = w_next_q ^ r_q;

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pc = w_pc + PC_W'(w_diff[i]);
        end
    end

    assign w_sum = SUM_W'(r_cnt) + SUM_W'(w_pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (w_sum > c_cnt_max) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        end
    end

    assign toggle_cnt = r_cnt;
`endif

    assign q      = r_q;
    assign qn     = ~r_q;
    assign q_chg  = r_q_chg;
    assign sr_err = r_sr_err;

endmodule : universal_ff_bank
`default_nettype wire

// File: tb/tb_universal_ff_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_universal_ff_bank
// Brief   : Directed scoreboard bench for universal_ff_bank.
// Revision: 1.0
// ============================================================================
module tb_universal_ff_bank;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       chg;
        logic       err;
        logic [15:0] cnt;
        logic [3:0] cnt4;
        logic       chk4;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       clr_err = 1'b0;
    logic [7:0] q, qn;
    logic       q_chg, sr_err;
    logic [7:0] q4, qn4;
    logic       q_chg4, sr_err4;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

`ifdef UFF_TOGGLE_CNT_EN
    logic [15:0] toggle_cnt;
    logic [3:0]  toggle_cnt4;
`endif

    universal_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .clr_err(clr_err), .q(q), .qn(qn), .q_chg(q_chg),
`ifdef UFF_TOGGLE_CNT_EN
        .toggle_cnt(toggle_cnt),
`endif
        .sr_err(sr_err)
    );

    universal_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .clr_err(clr_err), .q(q4), .qn(qn4), .q_chg(q_chg4),
`ifdef UFF_TOGGLE_CNT_EN
        .toggle_cnt(toggle_cnt4),
`endif
        .sr_err(sr_err4)
    );

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [7:0] va, input logic [7:0] vb, input logic c,
                         input string tag, input logic [7:0] eq, input logic ec,
                         input logic ee, input logic [15:0] ecnt,
                         input logic [3:0] ecnt4, input logic k4);
        exp_t e_item;
        @(negedge clk);
        rst = r; en = e; mode = m; a = va; b = vb; clr_err = c;
        e_item.tag = tag; e_item.q = eq; e_item.chg = ec; e_item.err = ee;
        e_item.cnt = ecnt; e_item.cnt4 = ecnt4; e_item.chk4 = k4;
        sb.push_back(e_item);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic check();
        exp_t x;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected>0");
        end
        if (sb.size() == 0) return;
        x = sb.pop_front();
        tests++;
        assert (q === x.q) else begin
            fails++; $error("FAIL %s.q observed=%h expected=%h", x.tag, q, x.q);
        end
        tests++;
        assert (qn === ~x.q) else begin
            fails++; $error("FAIL %s.qn observed=%h expected=%h", x.tag, qn, ~x.q);
        end
        tests++;
        assert (q_chg === x.chg) else begin
            fails++; $error("FAIL %s.q_chg observed=%b expected=%b", x.tag, q_chg, x.chg);
        end
        tests++;
        assert (sr_err === x.err) else begin
            fails++; $error("FAIL %s.sr_err observed=%b expected=%b", x.tag, sr_err, x.err);
        end
`ifdef UFF_TOGGLE_CNT_EN
        tests++;
        assert (toggle_cnt === x.cnt) else begin
            fails++; $error("FAIL %s.toggle_cnt observed=%0d expected=%0d", x.tag, toggle_cnt, x.cnt);
        end
        if (x.chk4) begin
            tests++;
            assert (toggle_cnt4 === x.cnt4) else begin
                fails++; $error("FAIL %s.toggle_cnt4 observed=%0d expected=%0d", x.tag, toggle_cnt4, x.cnt4);
            end
        end
`endif
    endtask

    initial begin
        //     rst  en   mode   a      b      clr   tag        q      chg   err   cnt   cnt4  chk4
        drive(1'b1, 1'b1, 2'b00, 8'hFF, 8'h00, 1'b0, "rst0",   8'h00, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1);
        drive(1'b1, 1'b1, 2'b00, 8'hFF, 8'h00, 1'b0, "rst1",   8'h00, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1);
        drive(1'b0, 1'b1, 2'b00, 8'hA5, 8'h00, 1'b0, "d_a5",   8'hA5, 1'b1, 1'b0, 16'd4, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 2'b00, 8'hA5, 8'h00, 1'b0, "d_rep",  8'hA5, 1'b0, 1'b0, 16'd4, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 2'b01, 8'h0F, 8'hFF, 1'b0, "t_1",    8'hAA, 1'b1, 1'b0, 16'd8, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 2'b01, 8'h0F, 8'hFF, 1'b0, "t_2",    8'hA5, 1'b1, 1'b0, 16'd12, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 2'b01, 8'h0F, 8'h00, 1'b0, "en0",    8'hA5, 1'b0, 1'b0, 16'd12, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, "d_00",   8'h00, 1'b1, 1'b0, 16'd16, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 2'b10, 8'hF0, 8'h3C, 1'b0, "jk_1",   8'hF0, 1'b1, 1'b0, 16'd20, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 2'b10, 8'hF0, 8'h3C, 1'b0, "jk_2",   8'hC0, 1'b1, 1'b0, 16'd22, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 2'b00, 8'h0F, 8'h00, 1'b0, "d_0f",   8'h0F, 1'b1, 1'b0, 16'd28, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 2'b11, 8'h81, 8'h03, 1'b0, "sr_1",   8'h8D, 1'b1, 1'b1, 16'd30, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 2'b11, 8'h01, 8'h01, 1'b0, "sr_hold",8'h8D, 1'b0, 1'b1, 16'd30, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 1'b1, "sr_clr", 8'h8D, 1'b0, 1'b0, 16'd30, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 2'b11, 8'h01, 8'h01, 1'b1, "sr_win", 8'h8D, 1'b0, 1'b1, 16'd30, 4'd0, 1'b0);
        drive(1'b1, 1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0, "rst_mid",8'h00, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1);
        drive(1'b0, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0, "sat_1",  8'hFF, 1'b1, 1'b0, 16'd8, 4'd8, 1'b1);
        drive(1'b0, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0, "sat_2",  8'h00, 1'b1, 1'b0, 16'd16, 4'd15, 1'b1);
        drive(1'b0, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0, "sat_3",  8'hFF, 1'b1, 1'b0, 16'd24, 4'd15, 1'b1);
        drive(1'b1, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0, "rst_en", 8'h00, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_universal_ff_bank
`default_nettype wire
